// File: rtl/learn_note_stepper_if.sv
// Bundle of mode, song ROM, player key and grader signals around learn_note_stepper.
// slave is the stepper's side; master is the surrounding system (ROM, keypad, grader).
`ifndef LEARN_MODE
`define LEARN_MODE 2'b10
`endif

interface learn_note_stepper_if;
    logic [1:0] state;
    logic       start;
    logic [5:0] song_len;
    logic [5:0] song_addr;
    logic [9:0] song_note;
    logic [9:0] store;
    logic [9:0] NOTE;
    logic       note_valid;
    logic       hit;
    logic       miss;
    logic [7:0] react_time;
    logic [5:0] hit_cnt;
    logic       done;

    modport master (
        output state, start, song_len, song_note, store,
        input  song_addr, NOTE, note_valid, hit, miss, react_time, hit_cnt, done
    );

    modport slave (
        input  state, start, song_len, song_note, store,
        output song_addr, NOTE, note_valid, hit, miss, react_time, hit_cnt, done
    );
endinterface

// File: rtl/learn_note_stepper.sv
// Learn-mode song stepper: walks the song ROM, presents each note, times the
// player's response in ticks and reports hit/miss per note.
`ifndef LEARN_MODE
`define LEARN_MODE 2'b10
`endif

module learn_note_stepper #(
    parameter int unsigned TICK_DIV      = 1_000_000,
    parameter int unsigned TIMEOUT_TICKS = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    learn_note_stepper_if.slave  bus
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, RELEASE, WAIT_KEY, ADVANCE, DONE
    } fsm_t;

    fsm_t            fsm_q, fsm_d;
    logic [5:0]      addr_q, addr_d;
    logic [9:0]      note_q, note_d;
    logic            nv_q, nv_d;
    logic            hit_q, hit_d;
    logic            miss_q, miss_d;
    logic [7:0]      react_q, react_d;
    logic [5:0]      hcnt_q, hcnt_d;
    logic            done_q, done_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      tick_q, tick_d;

    logic            tick_wrap_c;
    logic [PW-1:0]   presc_nxt_c;
    logic [7:0]      tick_nxt_c;
    logic            last_c;

    // State and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            addr_q  <= '0;
            note_q  <= '0;
            nv_q    <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            react_q <= '0;
            hcnt_q  <= '0;
            done_q  <= 1'b0;
            presc_q <= '0;
            tick_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            nv_q    <= nv_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            react_q <= react_d;
            hcnt_q  <= hcnt_d;
            done_q  <= done_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        fsm_d   = fsm_q;
        addr_d  = addr_q;
        note_d  = note_q;
        nv_d    = nv_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        react_d = react_q;
        hcnt_d  = hcnt_q;
        done_d  = done_q;
        presc_d = presc_q;
        tick_d  = tick_q;

        tick_wrap_c = (presc_q == PW'(TICK_DIV - 1));
        presc_nxt_c = tick_wrap_c ? '0 : PW'(presc_q + PW'(1));
        tick_nxt_c  = (tick_wrap_c && tick_q != 8'hFF) ? 8'(tick_q + 8'd1) : tick_q;
        last_c      = (7'({1'b0, addr_q}) + 7'd1) >= 7'({1'b0, bus.song_len});

        if (bus.state != `LEARN_MODE) begin
            fsm_d  = IDLE;
            note_d = '0;
            nv_d   = 1'b0;
            done_d = 1'b0;
        end else begin
            case (fsm_q)
                IDLE, DONE: begin
                    if (fsm_q == DONE) begin
                        done_d = 1'b1;
                        note_d = '0;
                    end
                    if (bus.start) begin
                        addr_d = '0;
                        hcnt_d = '0;
                        done_d = 1'b0;
                        note_d = '0;
                        fsm_d  = (bus.song_len == 6'd0) ? DONE : FETCH;
                    end
                end
                FETCH: fsm_d = LOAD;
                LOAD: begin
                    note_d = bus.song_note;
                    if (bus.song_note != 10'd0) begin
                        nv_d  = 1'b1;
                        fsm_d = RELEASE;
                    end else begin
                        fsm_d = ADVANCE;
                    end
                end
                // A key still held from the previous note must be let go first
                RELEASE: begin
                    if (bus.store == 10'd0) begin
                        presc_d = '0;
                        tick_d  = '0;
                        fsm_d   = WAIT_KEY;
                    end
                end
                WAIT_KEY: begin
                    presc_d = presc_nxt_c;
                    tick_d  = tick_nxt_c;
                    if (bus.store == note_q) begin
                        hit_d   = 1'b1;
                        react_d = tick_q;
                        hcnt_d  = (hcnt_q == 6'h3F) ? hcnt_q : 6'(hcnt_q + 6'd1);
                        nv_d    = 1'b0;
                        fsm_d   = ADVANCE;
                    end else if (tick_nxt_c == 8'(TIMEOUT_TICKS)) begin
                        miss_d = 1'b1;
                        nv_d   = 1'b0;
                        fsm_d  = ADVANCE;
                    end
                end
                ADVANCE: begin
                    note_d = '0;
                    if (last_c) begin
                        fsm_d = DONE;
                    end else begin
                        addr_d = 6'(addr_q + 6'd1);
                        fsm_d  = FETCH;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    assign bus.song_addr  = addr_q;
    assign bus.NOTE       = note_q;
    assign bus.note_valid = nv_q;
    assign bus.hit        = hit_q;
    assign bus.miss       = miss_q;
    assign bus.react_time = react_q;
    assign bus.hit_cnt    = hcnt_q;
    assign bus.done       = done_q;

endmodule

// File: doc/learn_note_stepper.md
LEARN_NOTE_STEPPER -- requirements
Module: learn_note_stepper

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1_000_000, meaning clock cycles per reaction tick (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_TICKS, default 200, meaning the number of ticks without a match before a note counts as a miss; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port state, input, 2 bits: global mode; the block runs only while it equals the shared `LEARN_MODE code.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins a song.
REQ-007 The block SHALL have port song_len, input, 6 bits: number of entries in the song; 0 means an empty song.
REQ-008 The block SHALL have port song_addr, output, 6 bits: song ROM address.
REQ-009 The block SHALL have port song_note, input, 10 bits: one-hot key code from the ROM, valid one cycle after song_addr; all-zero means a rest.
REQ-010 The block SHALL have port store, input, 10 bits: debounced player key vector.
REQ-011 The block SHALL have port NOTE, output, 10 bits: expected key vector for the downstream grader.
REQ-012 The block SHALL have port note_valid, output, 1 bit: high while NOTE is being presented.
REQ-013 The block SHALL have port hit, output, 1 bit: one-cycle pulse on a correct key.
REQ-014 The block SHALL have port miss, output, 1 bit: one-cycle pulse on a timeout.
REQ-015 The block SHALL have port react_time, output, 8 bits: ticks taken for the last hit; held until the next hit.
REQ-016 The block SHALL have port hit_cnt, output, 6 bits: number of hits in the current song.
REQ-017 The block SHALL have port done, output, 1 bit: high from song end until the next start or mode exit.

Function
REQ-018 The FSM states SHALL be IDLE, FETCH, LOAD, RELEASE, WAIT_KEY, ADVANCE, DONE.
REQ-019 In IDLE, start=1 with state==`LEARN_MODE SHALL clear song_addr, hit_cnt and done, then go to FETCH; if song_len==0 it SHALL go directly to DONE.
REQ-020 FETCH SHALL last one cycle to cover ROM latency. LOAD SHALL register song_note into NOTE; a non-zero note SHALL go to RELEASE and a rest SHALL go to ADVANCE with no pulse.
REQ-021 RELEASE SHALL wait until store==0 before entering WAIT_KEY, so a key held over from the previous note never scores; note_valid SHALL be 1 in RELEASE and WAIT_KEY only.
REQ-022 On entering WAIT_KEY, the cycle prescaler and the 8-bit tick counter SHALL clear. Each time the prescaler reaches TICK_DIV-1 it SHALL wrap to 0 and the tick counter SHALL increment, saturating at 255.
REQ-023 In WAIT_KEY, store==NOTE SHALL, in one cycle: pulse hit; load react_time with the current tick count; increment hit_cnt (saturating at 63); go to ADVANCE.
REQ-024 A non-zero store that differs from NOTE SHALL be ignored; there SHALL be no penalty and timing SHALL continue.
REQ-025 When the tick count reaches TIMEOUT_TICKS, WAIT_KEY SHALL pulse miss and go to ADVANCE. If a match and the timeout occur in the same cycle, hit SHALL win.
REQ-026 ADVANCE SHALL go to DONE when song_addr==song_len-1; otherwise it SHALL increment song_addr and go to FETCH. NOTE SHALL be cleared in ADVANCE.
REQ-027 DONE SHALL hold done=1 and NOTE=0. A start pulse in DONE SHALL restart as in IDLE.
REQ-028 From any state, state!=`LEARN_MODE SHALL force IDLE on the next edge: NOTE, note_valid and done cleared; hit_cnt and react_time held.
REQ-029 start pulses outside IDLE and DONE SHALL be ignored.
REQ-030 hit and miss SHALL never both be 1, and each SHALL be at most one pulse per song entry.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE and drive song_addr, NOTE, note_valid, hit, miss, react_time, hit_cnt, done and all internal counters to 0.
REQ-032 After rst deasserts, the block SHALL take no action until a start pulse; a reset mid-song SHALL abandon the song with no further pulses.

Verification (bench uses TICK_DIV=4, TIMEOUT_TICKS=10)
REQ-033 song_len=3, ROM {0x001,0x004,0x200}, each key pressed 3 ticks after note_valid -> 3 hit pulses, react_time=3 each, hit_cnt=3, done=1, song_addr ends at 2.
REQ-034 Never press a key on entry 0 -> miss pulse exactly 40 cycles after WAIT_KEY entry, no hit, advance to entry 1.
REQ-035 Hold 0x001 across the change from 0x001 to 0x001 (a repeated note) -> no second hit until store returns to 0 and is pressed again.
REQ-036 Wrong key 0x002 pressed on expected 0x001, then 0x001 pressed at tick 5 -> single hit, react_time=5.
REQ-037 ROM entry 1 = 0x000 (rest) -> no pulse for it, entry 2 fetched directly; song_len=0 -> done=1 two cycles after start.
REQ-038 Drop state out of `LEARN_MODE mid-WAIT_KEY, or pulse rst low -> NOTE=0 and note_valid=0 on that edge (immediately for rst), no hit or miss pulse.
